ten_bit_acc_ctrl: RTL and testbench

TEN_BIT_ACC_CTRL -- requirements
Module: ten_bit_acc_ctrl

---
 rtl/ten_bit_acc_ctrl.sv | 142 ++++++++++++++
 tb/tb_ten_bit_acc_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ten_bit_acc_ctrl.sv
// Burst accumulator controller: sums up to N_MAX 10-bit beats through an external adder.
// Optional macro ACC_SATURATE_EN clamps the accumulator to 10'h3FF on adder carry-out.
module ten_bit_acc_ctrl #(
  parameter int N_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [9:0] in_data,
  input  logic       in_last,
  output logic [9:0] add_a,
  output logic [9:0] add_b,
  output logic       add_ci,
  input  logic [9:0] add_s,
  input  logic       add_co,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [9:0] out_sum,
  output logic       out_ovf,
  output logic [3:0] out_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] N_MAX_C = 4'(N_MAX);

  state_t     state_r;
  state_t     next_state_s;
  logic [9:0] acc_r;
  logic [3:0] cnt_r;
  logic       ovf_r;
  logic       accept_s;
  logic       terminal_s;
  logic       consume_s;
  logic [3:0] cnt_inc_s;
  logic [9:0] acc_next_s;

  assign add_a  = acc_r;
  assign add_b  = in_data;
  assign add_ci = 1'b0;

  assign out_sum   = acc_r;
  assign out_ovf   = ovf_r;
  assign out_count = cnt_r;

  // Handshake qualifiers and the value loaded into the accumulator on a beat
  always_comb begin
    accept_s   = in_valid && in_ready;
    consume_s  = out_valid && out_ready;
    cnt_inc_s  = cnt_r + 4'd1;
    terminal_s = in_last || (cnt_inc_s == N_MAX_C);
`ifdef ACC_SATURATE_EN
    if (add_co) begin
      acc_next_s = 10'h3FF;
    end else begin
      acc_next_s = add_s;
    end
`else
    acc_next_s = add_s;
`endif
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE, ACCUM: begin
        if (accept_s && terminal_s) begin
          next_state_s = DONE;
        end else if (accept_s) begin
          next_state_s = ACCUM;
        end else begin
          next_state_s = state_r;
        end
      end
      DONE: begin
        if (out_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Output decode from the state register
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    case (state_r)
      IDLE, ACCUM: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
      DONE: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
    endcase
  end

  // Datapath: accumulate on accepted beats, clear when the result is consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r <= 10'd0;
      cnt_r <= 4'd0;
      ovf_r <= 1'b0;
    end else if (consume_s) begin
      acc_r <= 10'd0;
      cnt_r <= 4'd0;
      ovf_r <= 1'b0;
    end else if (accept_s) begin
      acc_r <= acc_next_s;
      cnt_r <= cnt_inc_s;
      ovf_r <= ovf_r | add_co;
    end else begin
      acc_r <= acc_r;
      cnt_r <= cnt_r;
      ovf_r <= ovf_r;
    end
  end

endmodule

// File: tb/tb_ten_bit_acc_ctrl.sv
// Directed self-checking bench for ten_bit_acc_ctrl with a behavioural external adder.
module tb_ten_bit_acc_ctrl;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] in_data;
  logic       in_last;
  logic [9:0] add_a;
  logic [9:0] add_b;
  logic       add_ci;
  logic [9:0] add_s;
  logic       add_co;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_sum;
  logic       out_ovf;
  logic [3:0] out_count;

  int n_checks = 0;
  int n_pass   = 0;

  ten_bit_acc_ctrl #(.N_MAX(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .add_a(add_a), .add_b(add_b), .add_ci(add_ci), .add_s(add_s), .add_co(add_co),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf), .out_count(out_count)
  );

  // External adder the block drives
  assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {10'd0, add_ci};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send_beat(input logic [9:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 10'd0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({in_ready, out_valid, out_sum, out_ovf, out_count} !== {1'b1, 1'b0, 10'd0, 1'b0, 4'd0})
      $display("FAIL reset_outputs: got rdy=%0b vld=%0b sum=%0d ovf=%0b cnt=%0d, want rdy=1 vld=0 sum=0 ovf=0 cnt=0",
               in_ready, out_valid, out_sum, out_ovf, out_count);
    else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL post_reset_idle: got rdy=%0b vld=%0b, want rdy=1 vld=0", in_ready, out_valid);
    else n_pass++;
  endtask

  task automatic test_basic_sum();
    send_beat(10'd10, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0 || out_sum !== 10'd10)
      $display("FAIL basic_partial: got vld=%0b sum=%0d, want vld=0 sum=10", out_valid, out_sum);
    else n_pass++;
    send_beat(10'd20, 1'b0);
    send_beat(10'd30, 1'b1);
    n_checks++;
    if ({out_valid, out_sum, out_count, out_ovf, in_ready} !== {1'b1, 10'd60, 4'd3, 1'b0, 1'b0})
      $display("FAIL basic_sum: got vld=%0b sum=%0d cnt=%0d ovf=%0b rdy=%0b, want vld=1 sum=60 cnt=3 ovf=0 rdy=0",
               out_valid, out_sum, out_count, out_ovf, in_ready);
    else n_pass++;
    consume();
    n_checks++;
    if ({out_valid, out_sum, out_count, out_ovf} !== {1'b0, 10'd0, 4'd0, 1'b0})
      $display("FAIL basic_consume: got vld=%0b sum=%0d cnt=%0d ovf=%0b, want all 0",
               out_valid, out_sum, out_count, out_ovf);
    else n_pass++;
  endtask

  task automatic test_overflow();
    logic [9:0] exp_sum;
`ifdef ACC_SATURATE_EN
    exp_sum = 10'd1023;
`else
    exp_sum = 10'd76;
`endif
    send_beat(10'd1000, 1'b0);
    n_checks++;
    if (out_ovf !== 1'b0)
      $display("FAIL ovf_early: got ovf=%0b, want 0", out_ovf);
    else n_pass++;
    send_beat(10'd100, 1'b1);
    n_checks++;
    if ({out_valid, out_sum, out_ovf, out_count} !== {1'b1, exp_sum, 1'b1, 4'd2})
      $display("FAIL ovf_sum: got vld=%0b sum=%0d ovf=%0b cnt=%0d, want vld=1 sum=%0d ovf=1 cnt=2",
               out_valid, out_sum, out_ovf, out_count, exp_sum);
    else n_pass++;
    consume();
    n_checks++;
    if (out_ovf !== 1'b0)
      $display("FAIL ovf_cleared: got ovf=%0b, want 0", out_ovf);
    else n_pass++;
  endtask

  task automatic test_nmax();
    for (int i = 0; i < 7; i++) send_beat(10'd1, 1'b0);
    n_checks++;
    if ({out_valid, in_ready, out_count} !== {1'b0, 1'b1, 4'd7})
      $display("FAIL nmax_seven: got vld=%0b rdy=%0b cnt=%0d, want vld=0 rdy=1 cnt=7",
               out_valid, in_ready, out_count);
    else n_pass++;
    send_beat(10'd1, 1'b0);
    n_checks++;
    if ({out_valid, in_ready, out_count, out_sum} !== {1'b1, 1'b0, 4'd8, 10'd8})
      $display("FAIL nmax_done: got vld=%0b rdy=%0b cnt=%0d sum=%0d, want vld=1 rdy=0 cnt=8 sum=8",
               out_valid, in_ready, out_count, out_sum);
    else n_pass++;
  endtask

  // Entered in DONE with sum=8, cnt=8
  task automatic test_hold();
    in_valid = 1'b1;
    in_data  = 10'd5;
    in_last  = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, in_ready, out_sum, out_count, out_ovf} !== {1'b1, 1'b0, 10'd8, 4'd8, 1'b0})
        $display("FAIL hold_cycle%0d: got vld=%0b rdy=%0b sum=%0d cnt=%0d ovf=%0b, want vld=1 rdy=0 sum=8 cnt=8 ovf=0",
                 i, out_valid, in_ready, out_sum, out_count, out_ovf);
      else n_pass++;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    n_checks++;
    if ({out_valid, in_ready, out_sum, out_count, out_ovf} !== {1'b0, 1'b1, 10'd0, 4'd0, 1'b0})
      $display("FAIL hold_release: got vld=%0b rdy=%0b sum=%0d cnt=%0d ovf=%0b, want vld=0 rdy=1 sum=0 cnt=0 ovf=0",
               out_valid, in_ready, out_sum, out_count, out_ovf);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    send_beat(10'd7, 1'b0);
    send_beat(10'd9, 1'b0);
    n_checks++;
    if ({out_sum, out_count} !== {10'd16, 4'd2})
      $display("FAIL arst_pre: got sum=%0d cnt=%0d, want sum=16 cnt=2", out_sum, out_count);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, out_valid, out_sum, out_ovf, out_count} !== {1'b1, 1'b0, 10'd0, 1'b0, 4'd0})
      $display("FAIL arst_immediate: got rdy=%0b vld=%0b sum=%0d ovf=%0b cnt=%0d, want rdy=1 vld=0 sum=0 ovf=0 cnt=0",
               in_ready, out_valid, out_sum, out_ovf, out_count);
    else n_pass++;
    #1 rst = 1'b0;
    @(posedge clk); #1;
    send_beat(10'd5, 1'b1);
    n_checks++;
    if ({out_valid, out_sum, out_count, out_ovf} !== {1'b1, 10'd5, 4'd1, 1'b0})
      $display("FAIL arst_new_burst: got vld=%0b sum=%0d cnt=%0d ovf=%0b, want vld=1 sum=5 cnt=1 ovf=0",
               out_valid, out_sum, out_count, out_ovf);
    else n_pass++;
    consume();
  endtask

  task automatic test_back_to_back();
    send_beat(10'd512, 1'b1);
    consume();
    send_beat(10'd3, 1'b1);
    n_checks++;
    if ({out_valid, out_sum, out_count} !== {1'b1, 10'd3, 4'd1})
      $display("FAIL b2b_second: got vld=%0b sum=%0d cnt=%0d, want vld=1 sum=3 cnt=1",
               out_valid, out_sum, out_count);
    else n_pass++;
    consume();
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 10'd0;
    in_last = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic_sum();
    test_overflow();
    test_nmax();
    test_hold();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
